l2_eviction_buffer: RTL and testbench

Single-entry write-back (victim) buffer between the L2 cache's memory-side port and physical memory. It absorbs a dirty 128-bit line evicted by L2, so the refill read for the missing line reaches memory first. It drains the held line to memory when the bus is idle. L2 reads that target the buffered line are served directly from the buffer.

---
 rtl/l2_eviction_buffer.sv | 118 +++++++++++
 tb/tb_l2_eviction_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_eviction_buffer.sv
// Single-entry victim buffer between the L2 memory-side port and physical memory.
// Refill reads overtake the held dirty line, which drains whenever the bus is idle.
module l2_eviction_buffer #(
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  l2_read,
    input  logic                  l2_write,
    input  logic [ADDR_WIDTH-1:0] l2_address,
    input  logic [LINE_WIDTH-1:0] l2_wdata,
    output logic [LINE_WIDTH-1:0] l2_rdata,
    output logic                  l2_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int TAG_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, RESP} state_t;

    state_t                state_reg;
    logic                  buf_valid_reg;
    logic [TAG_WIDTH-1:0]  buf_tag_reg;
    logic [LINE_WIDTH-1:0] buf_data_reg;
    logic [LINE_WIDTH-1:0] l2_rdata_reg;
    logic                  l2_resp_reg;
    logic                  pmem_read_reg;
    logic                  pmem_write_reg;
    logic [ADDR_WIDTH-1:0] pmem_address_reg;
    logic [LINE_WIDTH-1:0] pmem_wdata_reg;

    logic [TAG_WIDTH-1:0]  l2_tag;
    logic                  line_match;

    assign l2_tag     = l2_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign line_match = buf_valid_reg && (buf_tag_reg == l2_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            buf_valid_reg    <= 1'b0;
            buf_tag_reg      <= '0;
            buf_data_reg     <= '0;
            l2_rdata_reg     <= '0;
            l2_resp_reg      <= 1'b0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            pmem_address_reg <= '0;
            pmem_wdata_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (l2_read && line_match) begin
                        l2_rdata_reg <= buf_data_reg;
                        state_reg    <= RESP;
                    end else if (l2_read) begin
                        pmem_read_reg    <= 1'b1;
                        pmem_address_reg <= {l2_tag, {OFFSET_BITS{1'b0}}};
                        state_reg        <= FILL;
                    end else if (l2_write && (!buf_valid_reg || line_match)) begin
                        buf_valid_reg <= 1'b1;
                        buf_tag_reg   <= l2_tag;
                        buf_data_reg  <= l2_wdata;
                        state_reg     <= RESP;
                    end else if (l2_write || buf_valid_reg) begin
                        // A write to a different line stalls here; it is re-examined once the drain empties the buffer.
                        pmem_write_reg   <= 1'b1;
                        pmem_address_reg <= {buf_tag_reg, {OFFSET_BITS{1'b0}}};
                        pmem_wdata_reg   <= buf_data_reg;
                        state_reg        <= DRAIN;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        pmem_read_reg <= 1'b0;
                        l2_rdata_reg  <= pmem_rdata;
                        l2_resp_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                DRAIN: begin
                    if (pmem_resp) begin
                        pmem_write_reg <= 1'b0;
                        buf_valid_reg  <= 1'b0;
                        state_reg      <= IDLE;
                    end
                end
                RESP: begin
                    // Refills arrive with the pulse already raised; buffer hits and writes raise it here.
                    if (l2_resp_reg) begin
                        l2_resp_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        l2_resp_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign l2_rdata     = l2_rdata_reg;
    assign l2_resp      = l2_resp_reg;
    assign pmem_read    = pmem_read_reg;
    assign pmem_write   = pmem_write_reg;
    assign pmem_address = pmem_address_reg;
    assign pmem_wdata   = pmem_wdata_reg;

    a_single_request: assert property (@(posedge clk) disable iff (reset) !(l2_read && l2_write));

endmodule

// File: tb/tb_l2_eviction_buffer.sv
// Scoreboard bench for l2_eviction_buffer: expected L2 responses and memory
// transactions are queued by the stimulus and checked by independent monitors.
module tb_l2_eviction_buffer;

    localparam logic [127:0] DATA_A    = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    localparam logic [127:0] DATA_B    = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
    localparam logic [127:0] DATA_C    = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
    localparam logic [127:0] DATA_D    = 128'hDDDD_9999_DDDD_AAAA_DDDD_BBBB_DDDD_CCCC;
    localparam logic [127:0] LINE_4560 = 128'h4560_4560_4560_4560_4560_4560_4560_4560;
    localparam logic [127:0] LINE_9990 = 128'h9990_9990_9990_9990_9990_9990_9990_9990;

    logic         clk = 1'b0;
    logic         reset;
    logic         l2_read, l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata, l2_rdata;
    logic         l2_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    l2_eviction_buffer dut (
        .clk(clk), .reset(reset),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } pmem_txn_t;
    typedef struct { logic [127:0] data; bit chk; bit miss; } l2_txn_t;

    pmem_txn_t pmem_q[$];
    l2_txn_t   l2_q[$];
    pmem_txn_t cur;
    int  checks = 0, fails = 0, cyc = 0;
    int  mem_delay = 1, wait_cnt = 0, pmem_resp_cyc = -10;
    bit  mem_stall = 1'b0, in_txn = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: checks each new transaction against the expected queue and answers after mem_delay cycles.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (reset) begin
                in_txn = 1'b0;
            end else if (pmem_read || pmem_write) begin
                checks++;
                if (pmem_read && pmem_write) begin
                    fails++;
                    $display("FAIL pmem_overlap: read=%0b write=%0b, required not both", pmem_read, pmem_write);
                end
                if (!in_txn) begin
                    in_txn   = 1'b1;
                    wait_cnt = 0;
                    checks++;
                    if (pmem_q.size() == 0) begin
                        fails++;
                        $display("FAIL pmem_unexpected: write=%0b addr=%h, required no request", pmem_write, pmem_address);
                    end else begin
                        cur = pmem_q.pop_front();
                        if (pmem_write !== cur.wr || pmem_address !== cur.addr ||
                            (cur.wr && pmem_wdata !== cur.data)) begin
                            fails++;
                            $display("FAIL pmem_txn: got write=%0b addr=%h data=%h, required write=%0b addr=%h data=%h",
                                     pmem_write, pmem_address, pmem_wdata, cur.wr, cur.addr, cur.data);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
                if (!mem_stall && wait_cnt >= mem_delay - 1) begin
                    pmem_resp     = 1'b1;
                    pmem_rdata    = {8{pmem_address}};
                    pmem_resp_cyc = cyc;
                    in_txn        = 1'b0;
                end
            end
        end
    end

    // L2 response monitor.
    initial begin
        l2_txn_t e;
        forever begin
            @(negedge clk);
            if (!reset && l2_resp) begin
                checks++;
                if (l2_q.size() == 0) begin
                    fails++;
                    $display("FAIL l2_unexpected: got l2_resp with rdata=%h, required no response", l2_rdata);
                end else begin
                    e = l2_q.pop_front();
                    if (e.chk && l2_rdata !== e.data) begin
                        fails++;
                        $display("FAIL l2_rdata: got %h, required %h", l2_rdata, e.data);
                    end
                    if (e.miss) begin
                        checks++;
                        if (cyc != pmem_resp_cyc + 1) begin
                            fails++;
                            $display("FAIL l2_miss_latency: got %0d cycles after pmem_resp, required 1", cyc - pmem_resp_cyc);
                        end
                    end
                end
            end
        end
    end

    // Issues one L2 request and holds it until l2_resp; data is write data, or the expected read data.
    task automatic l2_req(input bit wr, input logic [15:0] addr, input logic [127:0] data,
                          input bit miss, input int exp_lat);
        l2_txn_t e;
        int n;
        e.data = data; e.chk = !wr; e.miss = miss;
        l2_q.push_back(e);
        l2_address = addr;
        l2_wdata   = wr ? data : '0;
        l2_read    = !wr;
        l2_write   = wr;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!l2_resp && n < 300);
        if (!l2_resp) begin
            checks++; fails++;
            $display("FAIL l2_timeout: addr=%h no l2_resp after %0d cycles, required a response", addr, n);
        end else if (exp_lat > 0) begin
            checks++;
            if (n != exp_lat) begin
                fails++;
                $display("FAIL l2_latency: addr=%h got %0d cycles, required %0d", addr, n, exp_lat);
            end
        end
        @(posedge clk); #1;
        l2_read  = 1'b0;
        l2_write = 1'b0;
        $display("l2 %s addr=%h done after %0d cycles", wr ? "write" : "read", addr, n);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pmem_q.size() != 0 || in_txn || pmem_read || pmem_write) && n < 300);
        checks++;
        if (pmem_q.size() != 0 || in_txn) begin
            fails++;
            $display("FAIL pmem_drain_timeout: %0d transactions outstanding, required 0", pmem_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_pmem_write();
        int n = 0;
        while (!pmem_write && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!pmem_write) begin
            fails++;
            $display("FAIL drain_start: pmem_write=%0b, required 1", pmem_write);
        end
    endtask

    initial begin
        reset = 1'b1; l2_read = 1'b0; l2_write = 1'b0; l2_address = '0; l2_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (l2_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 ||
            l2_rdata !== '0 || pmem_address !== '0) begin
            fails++;
            $display("FAIL reset_state: resp=%b rd=%b wr=%b rdata=%h addr=%h, required all 0",
                     l2_resp, pmem_read, pmem_write, l2_rdata, pmem_address);
        end
        @(posedge clk); #1;

        // Reset in the middle of a stalled drain discards the line.
        mem_stall = 1'b1;
        pmem_q.push_back('{1'b1, 16'h1110, DATA_D});
        l2_req(1'b1, 16'h1110, DATA_D, 1'b0, 2);
        wait_pmem_write();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || l2_resp !== 1'b0 || pmem_address !== '0) begin
            fails++;
            $display("FAIL reset_mid_drain: wr=%b rd=%b resp=%b addr=%h, required all 0",
                     pmem_write, pmem_read, l2_resp, pmem_address);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle: rd=%b wr=%b, required 0", pmem_read, pmem_write);
            end
        end
        mem_stall = 1'b0;
        $display("reset during drain done");
        @(posedge clk); #1;

        // Eviction, then a refill that overtakes the drain.
        mem_delay = 3;
        pmem_q.push_back('{1'b0, 16'h4560, '0});
        pmem_q.push_back('{1'b1, 16'h1230, DATA_A});
        l2_req(1'b1, 16'h1230, DATA_A, 1'b0, 2);
        l2_req(1'b0, 16'h4560, LINE_4560, 1'b1, 0);
        wait_idle();

        // Buffer hits and an overwrite of the same line: one drain with the newest data.
        mem_delay = 2;
        pmem_q.push_back('{1'b1, 16'h1230, DATA_C});
        l2_req(1'b1, 16'h1230, DATA_A, 1'b0, 2);
        l2_req(1'b0, 16'h1238, DATA_A, 1'b0, 2);
        l2_req(1'b1, 16'h1234, DATA_C, 1'b0, 2);
        l2_req(1'b0, 16'h123C, DATA_C, 1'b0, 2);
        wait_idle();

        // Write to a different line while full: old line drains first.
        pmem_q.push_back('{1'b1, 16'h1230, DATA_A});
        pmem_q.push_back('{1'b1, 16'h7770, DATA_B});
        l2_req(1'b1, 16'h1230, DATA_A, 1'b0, 2);
        l2_req(1'b1, 16'h7770, DATA_B, 1'b0, 0);
        wait_idle();

        // Read arriving mid-drain with slow memory, unaligned address.
        mem_delay = 5;
        pmem_q.push_back('{1'b1, 16'h2220, DATA_D});
        pmem_q.push_back('{1'b0, 16'h9990, '0});
        l2_req(1'b1, 16'h2220, DATA_D, 1'b0, 2);
        wait_pmem_write();
        @(posedge clk); #1;
        l2_req(1'b0, 16'h9994, LINE_9990, 1'b1, 0);
        wait_idle();

        repeat (4) @(posedge clk);
        checks++;
        if (l2_q.size() != 0 || pmem_q.size() != 0) begin
            fails++;
            $display("FAIL queues_empty: l2=%0d pmem=%0d outstanding, required 0", l2_q.size(), pmem_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
